// File: rtl/conv_layer_fc_seq.sv
// Fully-connected convolution layer, processed sequentially.
// Each kernel covers the whole K x K x N_CH feature map, so every kernel
// yields exactly one output point. The layer handles one tap per cycle for
// all N_OUT lanes in parallel. It then formats the accumulators into
// saturated fixed-point results, with optional ReLU, and holds them until
// the consumer accepts them.
module conv_layer_fc_seq #(
  parameter int BITWIDTH = 16,
  parameter int N_CH     = 2,
  parameter int N_OUT    = 10,
  parameter int K        = 5,
  parameter int FRAC     = 8,
  parameter int ACCW     = 40
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                relu_en,
  input  logic [N_CH*K*K*BITWIDTH-1:0]        featuremap_in,
  input  logic [N_OUT*N_CH*K*K*BITWIDTH-1:0]  kernel_in,
  input  logic [N_OUT*BITWIDTH-1:0]           bias_in,
  output logic                                busy,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [N_OUT*BITWIDTH-1:0]           featuremap_out
);

  localparam int TAPS = N_CH * K * K;
  localparam int TAPW = (TAPS > 1) ? $clog2(TAPS) : 1;

  // Saturation rails expressed at accumulator width.
  localparam logic signed [ACCW-1:0] SAT_MAX =
    {{(ACCW-BITWIDTH+1){1'b0}}, {(BITWIDTH-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FMT  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                       state;
  state_t                       state_nxt;
  logic [TAPW-1:0]              tap;
  logic                         relu_lat;
  logic                         last_tap;

  logic signed [ACCW-1:0]       acc      [N_OUT];
  logic signed [ACCW-1:0]       bias_ext [N_OUT];
  logic signed [BITWIDTH-1:0]   feat;
  logic signed [BITWIDTH-1:0]   kern     [N_OUT];
  logic signed [2*BITWIDTH-1:0] prod     [N_OUT];
  logic signed [ACCW-1:0]       prod_ext [N_OUT];
  logic signed [ACCW-1:0]       shifted  [N_OUT];
  logic signed [BITWIDTH-1:0]   res      [N_OUT];
  logic [N_OUT*BITWIDTH-1:0]    fmt_res;

  assign last_tap = (tap == TAPW'(TAPS - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: start only counts in IDLE, handshake only in DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
        else       state_nxt = IDLE;
      end
      RUN: begin
        if (last_tap) state_nxt = FMT;
        else          state_nxt = RUN;
      end
      FMT: state_nxt = DONE;
      DONE: begin
        if (out_ready) state_nxt = IDLE;
        else           state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy = (state != IDLE);
  end

  // Per-lane products for the current tap. The flat feature index is the tap
  // number itself, because the tap order (q fastest, then r, then c) matches
  // the packing order.
  always_comb begin
    feat = featuremap_in[int'(tap)*BITWIDTH +: BITWIDTH];
    for (int o = 0; o < N_OUT; o++) begin
      kern[o]     = kernel_in[(o*TAPS + int'(tap))*BITWIDTH +: BITWIDTH];
      prod[o]     = feat * kern[o];
      prod_ext[o] = {{(ACCW-2*BITWIDTH){prod[o][2*BITWIDTH-1]}}, prod[o]};
      bias_ext[o] = {{(ACCW-BITWIDTH){bias_in[o*BITWIDTH+BITWIDTH-1]}},
                     bias_in[o*BITWIDTH +: BITWIDTH]} <<< FRAC;
    end
  end

  // Result formatting: floor shift, saturate to BITWIDTH, optional ReLU.
  always_comb begin
    fmt_res = '0;
    for (int o = 0; o < N_OUT; o++) begin
      shifted[o] = acc[o] >>> FRAC;
      if (shifted[o] > SAT_MAX) begin
        res[o] = SAT_MAX[BITWIDTH-1:0];
      end else if (shifted[o] < SAT_MIN) begin
        res[o] = SAT_MIN[BITWIDTH-1:0];
      end else begin
        res[o] = shifted[o][BITWIDTH-1:0];
      end
      if (relu_lat && res[o][BITWIDTH-1]) begin
        res[o] = '0;
      end else begin
        res[o] = res[o];
      end
      fmt_res[o*BITWIDTH +: BITWIDTH] = res[o];
    end
  end

  // Datapath: bias preload, tap accumulation, result register and handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      tap            <= '0;
      relu_lat       <= 1'b0;
      out_valid      <= 1'b0;
      featuremap_out <= '0;
      for (int o = 0; o < N_OUT; o++) acc[o] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            tap      <= '0;
            relu_lat <= relu_en;
            for (int o = 0; o < N_OUT; o++) acc[o] <= bias_ext[o];
          end
        end
        RUN: begin
          for (int o = 0; o < N_OUT; o++) acc[o] <= acc[o] + prod_ext[o];
          if (!last_tap) tap <= tap + TAPW'(1);
        end
        FMT: begin
          featuremap_out <= fmt_res;
          out_valid      <= 1'b1;
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_layer_fc_seq.sv
// Directed, table-driven bench for conv_layer_fc_seq at default parameters.
module tb_conv_layer_fc_seq;

  localparam int BW    = 16;
  localparam int N_CH  = 2;
  localparam int N_OUT = 10;
  localparam int K     = 5;
  localparam int TAPS  = N_CH*K*K;
  localparam int LAT   = TAPS + 1;

  logic clk = 1'b0;
  logic rst, start, relu_en, out_ready;
  logic [TAPS*BW-1:0]       featuremap_in;
  logic [N_OUT*TAPS*BW-1:0] kernel_in;
  logic [N_OUT*BW-1:0]      bias_in;
  logic                     busy, out_valid;
  logic [N_OUT*BW-1:0]      featuremap_out;

  int checks = 0;
  int errors = 0;

  conv_layer_fc_seq dut (
    .clk(clk), .rst(rst), .start(start), .relu_en(relu_en),
    .featuremap_in(featuremap_in), .kernel_in(kernel_in), .bias_in(bias_in),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .featuremap_out(featuremap_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          fval;
    int          kval;
    bit          kscale;   // kernel o = kval*(o+1)
    int          bstep;    // bias o = bstep*o
    bit          relu;
    logic [N_OUT*BW-1:0] exp;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [N_OUT*BW-1:0] lanes(input int a0, a1, a2, a3, a4,
                                                a5, a6, a7, a8, a9);
    logic [N_OUT*BW-1:0] r;
    int a[N_OUT];
    a = '{a0, a1, a2, a3, a4, a5, a6, a7, a8, a9};
    for (int o = 0; o < N_OUT; o++) r[o*BW +: BW] = BW'(a[o]);
    return r;
  endfunction

  function automatic logic [N_OUT*BW-1:0] all_lanes(input int v);
    return lanes(v, v, v, v, v, v, v, v, v, v);
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [N_OUT*BW-1:0] exp);
    for (int o = 0; o < N_OUT; o++) begin
      chk($sformatf("%s lane%0d", nm, o),
          longint'($signed(featuremap_out[o*BW +: BW])),
          longint'($signed(exp[o*BW +: BW])));
    end
  endtask

  task automatic drive(input vec_t v);
    for (int t = 0; t < TAPS; t++) featuremap_in[t*BW +: BW] = BW'(v.fval);
    for (int o = 0; o < N_OUT; o++) begin
      for (int t = 0; t < TAPS; t++)
        kernel_in[(o*TAPS+t)*BW +: BW] = v.kscale ? BW'(v.kval*(o+1)) : BW'(v.kval);
      bias_in[o*BW +: BW] = BW'(v.bstep*o);
    end
    relu_en = v.relu;
  endtask

  // Pulse start, then count edges until out_valid; returns the count.
  task automatic start_and_wait(output int n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    drive(v);
    out_ready = 1'b0;
    @(negedge clk);
    start_and_wait(n);
    chk({v.name, " latency"}, n, LAT);
    chk_out(v.name, v.exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({v.name, " busy after ack"}, busy, 0);
    chk({v.name, " valid after ack"}, out_valid, 0);
  endtask

  initial begin
    int n;
    vecs[0] = '{"base",      256,    256,   1'b0, 0,   1'b0, all_lanes(12800)};
    vecs[1] = '{"sat_hi",    32767,  32767, 1'b0, 0,   1'b0, all_lanes(32767)};
    vecs[2] = '{"sat_lo",    32767, -32768, 1'b0, 0,   1'b0, all_lanes(-32768)};
    vecs[3] = '{"neg",       256,   -256,   1'b0, 0,   1'b0, all_lanes(-12800)};
    vecs[4] = '{"relu",      256,   -256,   1'b0, 0,   1'b1, all_lanes(0)};
    vecs[5] = '{"bias",      0,      256,   1'b0, 100, 1'b0,
                lanes(0, 100, 200, 300, 400, 500, 600, 700, 800, 900)};
    vecs[6] = '{"kscale",    256,    256,   1'b1, 0,   1'b0,
                lanes(12800, 25600, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767)};
    vecs[7] = '{"floor_neg", 1,     -1,     1'b0, 0,   1'b0, all_lanes(-1)};
    vecs[8] = '{"floor_pos", 1,      1,     1'b0, 0,   1'b0, all_lanes(0)};
    vecs[9] = '{"neg_bias",  0,      5,     1'b0, -7,  1'b0,
                lanes(0, -7, -14, -21, -28, -35, -42, -49, -56, -63)};

    rst = 1'b1; start = 1'b0; relu_en = 1'b0; out_ready = 1'b0;
    featuremap_in = '0; kernel_in = '0; bias_in = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset valid", out_valid, 0);
    chk_out("reset out", '0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Hold in DONE with out_ready low and start pulsing; start ignored.
    drive(vecs[0]);
    @(negedge clk);
    start_and_wait(n);
    chk("hold latency", n, LAT);
    drive(vecs[3]);   // inputs may change once results are registered
    for (int c = 0; c < 10; c++) begin
      start = c[0];
      @(negedge clk);
      chk($sformatf("hold valid c%0d", c), out_valid, 1);
      chk($sformatf("hold busy c%0d", c), busy, 1);
      chk_out($sformatf("hold c%0d", c), vecs[0].exp);
    end
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b0;
    chk("ack+start busy", busy, 0);
    chk("ack+start valid", out_valid, 0);
    chk_out("kept after ack", vecs[0].exp);
    @(negedge clk);
    chk("start at ack ignored", busy, 0);

    // Reset 20 cycles into a run clears everything; a fresh run then works.
    drive(vecs[0]);
    out_ready = 1'b1;   // ignored outside DONE
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid-run busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst valid", out_valid, 0);
    chk_out("rst out", '0);
    start = 1'b1;          // coincident with rst: must be ignored
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("start with rst ignored", busy, 0);
    run_vec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
